// File: rtl/atmega_exint.sv
// ATmega-style external (INTn) and pin-change interrupt controller on the 8-bit I/O bus.
// Pins are double-synchronised, edge-detected against a history stage, and gated by a warm-up counter.
module atmega_exint #(
   parameter PLATFORM = "XILINX",
   parameter int unsigned BUS_ADDR_DATA_LEN = 8,
   parameter int unsigned PORT_WIDTH = 8,
   parameter int unsigned EXT_INT_COUNT = 2,
   parameter logic [BUS_ADDR_DATA_LEN-1:0] EICRA_ADDR = 'h69,
   parameter logic [BUS_ADDR_DATA_LEN-1:0] EIMSK_ADDR = 'h3D,
   parameter logic [BUS_ADDR_DATA_LEN-1:0] EIFR_ADDR  = 'h3C,
   parameter logic [BUS_ADDR_DATA_LEN-1:0] PCICR_ADDR = 'h68,
   parameter logic [BUS_ADDR_DATA_LEN-1:0] PCIFR_ADDR = 'h3B,
   parameter logic [BUS_ADDR_DATA_LEN-1:0] PCMSK_ADDR = 'h6B
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [BUS_ADDR_DATA_LEN-1:0] addr_dat,
   input  logic                         wr_dat,
   input  logic                         rd_dat,
   input  logic [7:0]                   bus_dat_in,
   output logic [7:0]                   bus_dat_out,
   input  logic [EXT_INT_COUNT-1:0]     ext_in,
   input  logic [PORT_WIDTH-1:0]        pc_in,
   output logic [EXT_INT_COUNT-1:0]     int_req,
   input  logic [EXT_INT_COUNT-1:0]     int_ack,
   output logic                         pcint_req,
   input  logic                         pcint_ack
);

   logic [EXT_INT_COUNT-1:0]   r_ext_s1, r_ext_s2, r_ext_s3;
   logic [PORT_WIDTH-1:0]      r_pc_s1, r_pc_s2, r_pc_s3;
   logic [1:0]                 r_warm;

   logic [2*EXT_INT_COUNT-1:0] r_eicra;
   logic [EXT_INT_COUNT-1:0]   r_eimsk;
   logic [EXT_INT_COUNT-1:0]   r_eifr;
   logic                       r_pcicr;
   logic                       r_pcifr;
   logic [PORT_WIDTH-1:0]      r_pcmsk;

   logic                       w_warm_done;
   logic [EXT_INT_COUNT-1:0]   w_ext_rise, w_ext_fall, w_ext_edge;
   logic [PORT_WIDTH-1:0]      w_pc_edge;
   logic                       w_wr_eicra, w_wr_eimsk, w_wr_eifr;
   logic                       w_wr_pcicr, w_wr_pcifr, w_wr_pcmsk;
   logic [EXT_INT_COUNT-1:0]   w_eifr_set, w_eifr_clr, w_eifr_nxt;
   logic                       w_pcifr_set, w_pcifr_clr, w_pcifr_nxt;

   assign w_warm_done = (r_warm == 2'd3);
   assign w_ext_rise  = r_ext_s2 & ~r_ext_s3;
   assign w_ext_fall  = ~r_ext_s2 & r_ext_s3;
   assign w_ext_edge  = r_ext_s2 ^ r_ext_s3;
   assign w_pc_edge   = r_pc_s2 ^ r_pc_s3;

   assign w_wr_eicra = wr_dat && (addr_dat == EICRA_ADDR);
   assign w_wr_eimsk = wr_dat && (addr_dat == EIMSK_ADDR);
   assign w_wr_eifr  = wr_dat && (addr_dat == EIFR_ADDR);
   assign w_wr_pcicr = wr_dat && (addr_dat == PCICR_ADDR);
   assign w_wr_pcifr = wr_dat && (addr_dat == PCIFR_ADDR);
   assign w_wr_pcmsk = wr_dat && (addr_dat == PCMSK_ADDR);

   // Sense 00 (low level) never sets the flag; the request follows the pin instead.
   always_comb begin
      w_eifr_set = '0;
      int_req    = '0;
      for (int unsigned n = 0; n < EXT_INT_COUNT; n++) begin
         case (r_eicra[2*n +: 2])
            2'b01:   w_eifr_set[n] = w_ext_edge[n] & w_warm_done;
            2'b10:   w_eifr_set[n] = w_ext_fall[n] & w_warm_done;
            2'b11:   w_eifr_set[n] = w_ext_rise[n] & w_warm_done;
            default: w_eifr_set[n] = 1'b0;
         endcase
         if (r_eicra[2*n +: 2] == 2'b00)
            int_req[n] = r_eimsk[n] & ~r_ext_s2[n];
         else
            int_req[n] = r_eimsk[n] & r_eifr[n];
      end
   end

   // Clear by write-1 or ack; a same-cycle set event takes priority.
   assign w_eifr_clr  = (w_wr_eifr ? bus_dat_in[EXT_INT_COUNT-1:0] : '0) | int_ack;
   assign w_eifr_nxt  = (r_eifr & ~w_eifr_clr) | w_eifr_set;

   assign w_pcifr_set = (|(w_pc_edge & r_pcmsk)) & w_warm_done;
   assign w_pcifr_clr = (w_wr_pcifr & bus_dat_in[0]) | pcint_ack;
   assign w_pcifr_nxt = (r_pcifr & ~w_pcifr_clr) | w_pcifr_set;

   assign pcint_req = r_pcicr & r_pcifr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ext_s1 <= '0;
         r_ext_s2 <= '0;
         r_ext_s3 <= '0;
         r_pc_s1  <= '0;
         r_pc_s2  <= '0;
         r_pc_s3  <= '0;
         r_warm   <= '0;
         r_eicra  <= '0;
         r_eimsk  <= '0;
         r_eifr   <= '0;
         r_pcicr  <= 1'b0;
         r_pcifr  <= 1'b0;
         r_pcmsk  <= '0;
      end else begin
         r_ext_s1 <= ext_in;
         r_ext_s2 <= r_ext_s1;
         r_ext_s3 <= r_ext_s2;
         r_pc_s1  <= pc_in;
         r_pc_s2  <= r_pc_s1;
         r_pc_s3  <= r_pc_s2;
         if (!w_warm_done)
            r_warm <= r_warm + 2'd1;
         if (w_wr_eicra)
            r_eicra <= bus_dat_in[2*EXT_INT_COUNT-1:0];
         if (w_wr_eimsk)
            r_eimsk <= bus_dat_in[EXT_INT_COUNT-1:0];
         if (w_wr_pcicr)
            r_pcicr <= bus_dat_in[0];
         if (w_wr_pcmsk)
            r_pcmsk <= bus_dat_in[PORT_WIDTH-1:0];
         r_eifr  <= w_eifr_nxt;
         r_pcifr <= w_pcifr_nxt;
      end
   end

   always_comb begin
      bus_dat_out = '0;
      if (rst && rd_dat) begin
         case (addr_dat)
            EICRA_ADDR: bus_dat_out = 8'(r_eicra);
            EIMSK_ADDR: bus_dat_out = 8'(r_eimsk);
            EIFR_ADDR:  bus_dat_out = 8'(r_eifr);
            PCICR_ADDR: bus_dat_out = {7'b0, r_pcicr};
            PCIFR_ADDR: bus_dat_out = {7'b0, r_pcifr};
            PCMSK_ADDR: bus_dat_out = 8'(r_pcmsk);
            default:    bus_dat_out = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_atmega_exint.sv
// Directed bench for atmega_exint: expectations are queued as stimulus is applied,
// then popped and compared when the DUT output is sampled.
module tb_atmega_exint;

   localparam logic [7:0] A_EICRA = 8'h69;
   localparam logic [7:0] A_EIMSK = 8'h3D;
   localparam logic [7:0] A_EIFR  = 8'h3C;
   localparam logic [7:0] A_PCICR = 8'h68;
   localparam logic [7:0] A_PCIFR = 8'h3B;
   localparam logic [7:0] A_PCMSK = 8'h6B;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] addr_dat;
   logic       wr_dat;
   logic       rd_dat;
   logic [7:0] bus_dat_in;
   logic [7:0] bus_dat_out;
   logic [1:0] ext_in;
   logic [7:0] pc_in;
   logic [1:0] int_req;
   logic [1:0] int_ack;
   logic       pcint_req;
   logic       pcint_ack;

   typedef struct {
      string      tag;
      logic [7:0] exp;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   atmega_exint #(
      .PLATFORM("XILINX"),
      .BUS_ADDR_DATA_LEN(8),
      .PORT_WIDTH(8),
      .EXT_INT_COUNT(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .addr_dat(addr_dat),
      .wr_dat(wr_dat),
      .rd_dat(rd_dat),
      .bus_dat_in(bus_dat_in),
      .bus_dat_out(bus_dat_out),
      .ext_in(ext_in),
      .pc_in(pc_in),
      .int_req(int_req),
      .int_ack(int_ack),
      .pcint_req(pcint_req),
      .pcint_ack(pcint_ack)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input string tag, input logic [7:0] v);
      sb.push_back('{tag, v});
   endtask

   task automatic pop_chk(input logic [7:0] obs);
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty observed=%h required=<entry>", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.exp) else begin
            errors++;
            $error("FAIL %s observed=%h required=%h", e.tag, obs, e.exp);
         end
      end
   endtask

   task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] v);
      push(tag, v);
      addr_dat = a;
      rd_dat   = 1'b1;
      #1;
      pop_chk(bus_dat_out);
      rd_dat   = 1'b0;
   endtask

   task automatic sig_chk(input string tag, input logic [7:0] obs, input logic [7:0] v);
      push(tag, v);
      pop_chk(obs);
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      addr_dat   = a;
      bus_dat_in = d;
      wr_dat     = 1'b1;
      tick();
      wr_dat     = 1'b0;
   endtask

   initial begin
      rst = 1'b0; addr_dat = '0; wr_dat = 1'b0; rd_dat = 1'b0; bus_dat_in = '0;
      ext_in = 2'b11; pc_in = 8'hFF; int_ack = '0; pcint_ack = 1'b0;

      // Reset with pins high; warm-up must hide the zero-to-one ramp of the sync chain
      repeat (3) tick();
      rd_chk("rd_in_reset", A_EIMSK, 8'h00);
      rst = 1'b1;
      repeat (10) tick();
      rd_chk("rst_eicra", A_EICRA, 8'h00);
      rd_chk("rst_eimsk", A_EIMSK, 8'h00);
      rd_chk("rst_eifr",  A_EIFR,  8'h00);
      rd_chk("rst_pcicr", A_PCICR, 8'h00);
      rd_chk("rst_pcifr", A_PCIFR, 8'h00);
      rd_chk("rst_pcmsk", A_PCMSK, 8'h00);
      rd_chk("rst_unknown", 8'h50, 8'h00);
      sig_chk("rst_int_req", {6'b0, int_req}, 8'h00);
      sig_chk("rst_pcint_req", {7'b0, pcint_req}, 8'h00);

      // Unimplemented bits read as zero
      wr(A_EIMSK, 8'hFF); rd_chk("eimsk_mask", A_EIMSK, 8'h03);
      wr(A_EICRA, 8'hFF); rd_chk("eicra_mask", A_EICRA, 8'h0F);
      wr(A_PCICR, 8'hFF); rd_chk("pcicr_mask", A_PCICR, 8'h01);
      wr(A_PCICR, 8'h00);

      // Rising edge on INT0
      wr(A_EICRA, 8'h03);
      wr(A_EIMSK, 8'h01);
      ext_in = 2'b10;
      repeat (4) tick();
      rd_chk("fall_in_rise_mode", A_EIFR, 8'h00);
      tick();
      ext_in = 2'b11;
      tick(); tick();
      rd_chk("rise_lat2_eifr", A_EIFR, 8'h00);
      sig_chk("rise_lat2_req", {6'b0, int_req}, 8'h00);
      tick();
      rd_chk("rise_lat3_eifr", A_EIFR, 8'h01);
      sig_chk("rise_lat3_req", {6'b0, int_req}, 8'h01);
      int_ack = 2'b01;
      tick();
      int_ack = 2'b00;
      rd_chk("ack_eifr", A_EIFR, 8'h00);
      sig_chk("ack_req", {6'b0, int_req}, 8'h00);

      // Level mode on INT0
      wr(A_EICRA, 8'h00);
      sig_chk("lvl_high_req", {6'b0, int_req}, 8'h00);
      ext_in = 2'b10;
      tick();
      sig_chk("lvl_low_1clk", {6'b0, int_req}, 8'h00);
      tick();
      sig_chk("lvl_low_2clk", {6'b0, int_req}, 8'h01);
      rd_chk("lvl_eifr", A_EIFR, 8'h00);
      ext_in = 2'b11;
      tick();
      sig_chk("lvl_high_1clk", {6'b0, int_req}, 8'h01);
      tick();
      sig_chk("lvl_high_2clk", {6'b0, int_req}, 8'h00);

      // Pin-change masking
      wr(A_PCMSK, 8'h04);
      wr(A_PCICR, 8'h01);
      pc_in = 8'hF7;
      repeat (4) tick();
      rd_chk("pc_masked_flag", A_PCIFR, 8'h00);
      sig_chk("pc_masked_req", {7'b0, pcint_req}, 8'h00);
      pc_in = 8'hF3;
      tick(); tick();
      rd_chk("pc_lat2_flag", A_PCIFR, 8'h00);
      tick();
      rd_chk("pc_lat3_flag", A_PCIFR, 8'h01);
      sig_chk("pc_lat3_req", {7'b0, pcint_req}, 8'h01);
      wr(A_PCIFR, 8'h01);
      rd_chk("pc_clr_flag", A_PCIFR, 8'h00);
      sig_chk("pc_clr_req", {7'b0, pcint_req}, 8'h00);

      // Set event and write-1 clear on the same edge
      wr(A_EICRA, 8'h03);
      ext_in = 2'b10;
      repeat (4) tick();
      ext_in = 2'b11;
      tick(); tick();
      wr(A_EIFR, 8'h01);
      rd_chk("collide_set_wins", A_EIFR, 8'h01);
      wr(A_EIFR, 8'h00);
      rd_chk("write0_keeps", A_EIFR, 8'h01);
      wr(A_EIFR, 8'h01);
      rd_chk("write1_clears", A_EIFR, 8'h00);

      // Asynchronous reset while both requests are active
      wr(A_EICRA, 8'h00);
      wr(A_EIMSK, 8'h03);
      ext_in = 2'b00;
      tick(); tick();
      sig_chk("pre_reset_req", {6'b0, int_req}, 8'h03);
      rst = 1'b0;
      #1;
      sig_chk("async_reset_req", {6'b0, int_req}, 8'h00);
      rd_chk("async_reset_rd", A_EIMSK, 8'h00);
      tick(); tick();
      rst = 1'b1;
      repeat (4) tick();
      rd_chk("post_reset_eimsk", A_EIMSK, 8'h00);
      rd_chk("post_reset_eicra", A_EICRA, 8'h00);
      sig_chk("post_reset_req", {6'b0, int_req}, 8'h00);

      if (sb.size() != 0) begin
         errors++;
         $error("FAIL scoreboard_leftover observed=%0d required=0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/atmega_exint.md
Name: atmega_exint

Overview:
- ATmega-style external-interrupt and pin-change-interrupt controller; the input-side counterpart of the PIO block.
- Samples pins driven from outside the core and sets interrupt flags on selected conditions.
- Raises request lines to the CPU interrupt unit and clears them on the vector-acknowledge handshake.
- Attaches to the same 8-bit I/O data bus as the other peripherals. Register semantics: EICRA, EIMSK, EIFR, PCICR, PCIFR, PCMSK.

Parameters:
- PLATFORM, "XILINX", target platform tag (no behavioural effect)
- BUS_ADDR_DATA_LEN, 8, width of addr_dat
- PORT_WIDTH, 8, number of pin-change inputs (max 8)
- EXT_INT_COUNT, 2, number of INTn inputs (max 4)
- EICRA_ADDR, 'h69, sense-control register address
- EIMSK_ADDR, 'h3D, external interrupt mask address
- EIFR_ADDR, 'h3C, external interrupt flag address
- PCICR_ADDR, 'h68, pin-change enable address
- PCIFR_ADDR, 'h3B, pin-change flag address
- PCMSK_ADDR, 'h6B, pin-change mask address

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- addr_dat  in  BUS_ADDR_DATA_LEN  I/O register address
- wr_dat  in  1  write strobe, one cycle per write
- rd_dat  in  1  read strobe
- bus_dat_in  in  8  write data
- bus_dat_out  out  8  read data, combinational
- ext_in  in  EXT_INT_COUNT  asynchronous INTn pins
- pc_in  in  PORT_WIDTH  asynchronous pin-change pins
- int_req  out  EXT_INT_COUNT  INTn interrupt requests
- int_ack  in  EXT_INT_COUNT  one-cycle vector-taken pulses
- pcint_req  out  1  pin-change interrupt request
- pcint_ack  in  1  one-cycle vector-taken pulse

Behaviour:

Reset (rst low):
- Immediately clears all registers, synchronizer stages, the history stage and the warm-up counter.
- int_req = 0, pcint_req = 0.
- bus_dat_out = 0 while rst is low.

Synchronizer and warm-up:
- Each ext_in and pc_in bit passes through two flops (s1, s2), then a history flop s3.
- Edge = s2 XOR s3; rise = s2 & ~s3; fall = ~s2 & s3.
- A 2-bit warm-up counter counts 0..3 after reset release, then saturates.
- Flags cannot set until the counter reaches 3, which suppresses false edges caused by the zero-reset chain.

External interrupts (per INTn):
- Sense field EICRA[2n+1:2n]: 00 low level, 01 any edge, 10 falling, 11 rising.
- Edge modes: EIFR[n] sets on the selected edge at the clock after s2 changes, regardless of EIMSK.
- Latency: 3 rising clk edges from pin change to EIFR set.
- int_req[n] = EIMSK[n] & EIFR[n] (combinational from registers).
- Level mode: EIFR[n] never sets. int_req[n] = EIMSK[n] & ~s2[n], and int_ack has no effect.
- Writing EICRA does not alter EIFR and does not itself generate an edge.

Pin change:
- PCIFR[0] sets when |(edge & PCMSK) is true and warm-up is complete.
- pcint_req = PCICR[0] & PCIFR[0].

Flag clearing:
- Writing 1 to a flag bit clears it; writing 0 leaves it unchanged.
- The matching ack pulse also clears it.
- If a set event and a clear (write-1 or ack) occur in the same cycle, set wins.

Register access:
- Writes are synchronous, taken when wr_dat is high and addr_dat matches.
- Unimplemented bits are forced to 0 on write and read as 0.
  - EIMSK/EIFR implement EXT_INT_COUNT bits.
  - EICRA implements 2*EXT_INT_COUNT bits.
  - PCICR/PCIFR implement bit 0 only.
  - PCMSK implements PORT_WIDTH bits.
- Reads are combinational when rd_dat is high. Unknown addresses return 0; bus_dat_out = 0 when rd_dat is low.
- Simultaneous rd_dat and wr_dat to the same address returns the pre-write value.

Test Plan:
1. Reset: hold rst low with ext_in=2'b11 and pc_in=8'hFF, then release. Required: no flag sets in the following 10 cycles; all register reads return 8'h00.
2. Rising edge: EICRA=8'h03, EIMSK=8'h01, toggle ext_in[0] 0->1. Required: EIFR=8'h01 and int_req[0]=1 exactly 3 clks later. Pulse int_ack[0]: EIFR=8'h00 and int_req[0]=0 the next cycle.
3. Level mode: EICRA=8'h00, EIMSK=8'h01, drive ext_in[0]=0. Required: int_req[0]=1 two clks later, EIFR remains 8'h00. Drive ext_in[0]=1: int_req[0]=0 two clks later.
4. Pin change masking: PCMSK=8'h04, PCICR=8'h01. Toggle pc_in[3]: PCIFR stays 0. Toggle pc_in[2]: PCIFR=8'h01, pcint_req=1. Write PCIFR=8'h01: clears it.
5. Set-vs-clear collision: edge event and write EIFR=8'h01 land on the same clock. Required: EIFR reads 8'h01 afterwards.
6. Mid-operation reset: assert rst while int_req=2'b11. Required: int_req=0 asynchronously before the next clk edge; EIMSK and EICRA read 0 after release.
